// File: rtl/pedal_speed_ramp.sv
// pedal_speed_ramp: block-averages the accelerator pedal channel of the ADC
// response stream, maps the average to a target speed, and ramps the vehicle
// speed toward that target on a fixed tick with a small direction FSM.
module pedal_speed_ramp #(
  parameter logic [4:0]  CHANNEL    = 5'd1,
  parameter int unsigned AVG_LOG2   = 3,
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned MAX_SPEED  = 225,
  parameter int unsigned ACCEL_STEP = 2,
  parameter int unsigned DECEL_STEP = 1,
  parameter int unsigned BRAKE_STEP = 4,
  parameter int unsigned MIN_MOTOR  = 10
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic [1:0]  gear,
  output logic [11:0] pedal_pos,
  output logic [7:0]  target_speed,
  output logic [7:0]  speed,
  output logic        dir_rev,
  output logic        speed_tick,
  output logic        motor_fwd,
  output logic        motor_rev
);

  localparam int unsigned ACC_W  = 12 + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam logic [8:0] MAX_S   = 9'(MAX_SPEED);
  localparam logic [8:0] ACCEL_S = 9'(ACCEL_STEP);
  localparam logic [8:0] DECEL_S = 9'(DECEL_STEP);
  localparam logic [8:0] BRAKE_S = 9'(BRAKE_STEP);
  localparam logic [7:0] MIN_M   = 8'(MIN_MOTOR);

  localparam logic [1:0] GEAR_NEUTRAL = 2'b00;
  localparam logic [1:0] GEAR_REVERSE = 2'b01;
  localparam logic [1:0] GEAR_DRIVE   = 2'b10;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2
  } state_t;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [11:0]       pedal_q, pedal_d;
  logic [7:0]        target_q, target_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        speed_q, speed_d;
  state_t            state_q, state_d;

  logic              accept;
  logic [ACC_W-1:0]  sum;
  logic [19:0]       product;
  logic [7:0]        target_raw;
  logic              tick;
  logic [8:0]        spd9, tgt9;
  logic [8:0]        diff, toward, next_spd;
  logic              matching;

  function automatic logic [8:0] sat_sub(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? (a - b) : 9'd0;
  endfunction

  function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [8:0] b);
    logic [8:0] s;
    s = a + b;
    return (s > MAX_S) ? MAX_S : s;
  endfunction

  assign accept = response_valid && (response_channel == CHANNEL);
  assign sum    = acc_q + ACC_W'(response_data);
  assign tick   = (tick_cnt_q == TICK_LAST);
  assign spd9   = {1'b0, speed_q};
  assign tgt9   = {1'b0, target_q};

  // Block averager: sum accepted pedal samples, publish the mean when the block fills
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pedal_d = pedal_q;
    if (accept) begin
      if (cnt_q == CNT_LAST) begin
        pedal_d = 12'(sum >> AVG_LOG2);
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Target speed scales the registered pedal average to full-scale MAX_SPEED
  always_comb begin
    product    = 20'(pedal_q) * 20'(MAX_SPEED);
    target_raw = 8'(product >> 12);
    target_d   = (9'(target_raw) > MAX_S) ? MAX_S[7:0] : target_raw;
  end

  // Free-running ramp tick divider; the wrap cycle is the tick
  always_comb begin
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_W'(1));
  end

  // Direction FSM and speed ramp, only advanced on a tick
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    diff     = '0;
    toward   = spd9;
    next_spd = spd9;
    matching = 1'b0;
    if (tgt9 > spd9) begin
      diff   = tgt9 - spd9;
      toward = sat_add(spd9, (diff < ACCEL_S) ? diff : ACCEL_S);
    end else begin
      diff   = spd9 - tgt9;
      toward = spd9 - ((diff < DECEL_S) ? diff : DECEL_S);
    end
    if (tick) begin
      case (state_q)
        ST_STOP: begin
          if ((target_q != 8'd0) && (gear == GEAR_DRIVE)) begin
            state_d = ST_FWD;
          end else if ((target_q != 8'd0) && (gear == GEAR_REVERSE)) begin
            state_d = ST_REV;
          end
        end
        ST_FWD, ST_REV: begin
          matching = ((state_q == ST_FWD) && (gear == GEAR_DRIVE)) ||
                     ((state_q == ST_REV) && (gear == GEAR_REVERSE));
          if (matching) begin
            next_spd = toward;
          end else if (gear == GEAR_NEUTRAL) begin
            next_spd = sat_sub(spd9, DECEL_S);
          end else begin
            // park and the opposite gear both brake hard
            next_spd = sat_sub(spd9, BRAKE_S);
          end
          if (next_spd == 9'd0) begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d  = ST_STOP;
          next_spd = '0;
        end
      endcase
      speed_d = next_spd[7:0];
    end
  end

  // State register with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      pedal_q    <= '0;
      target_q   <= '0;
      tick_cnt_q <= '0;
      speed_q    <= '0;
      state_q    <= ST_STOP;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      pedal_q    <= pedal_d;
      target_q   <= target_d;
      tick_cnt_q <= tick_cnt_d;
      speed_q    <= speed_d;
      state_q    <= state_d;
    end
  end

  assign pedal_pos    = pedal_q;
  assign target_speed = target_q;
  assign speed        = speed_q;
  assign speed_tick   = tick;
  assign dir_rev      = (state_q == ST_REV);
  assign motor_fwd    = (state_q == ST_FWD) && (speed_q >= MIN_M);
  assign motor_rev    = (state_q == ST_REV) && (speed_q >= MIN_M);

endmodule

// File: tb/tb_pedal_speed_ramp.sv
// tb_pedal_speed_ramp: directed stimulus for pedal_speed_ramp with a
// tick-driven scoreboard. Expected per-tick speed/direction values are queued
// by the stimulus thread and checked by an independent monitor.
module tb_pedal_speed_ramp;

  logic        sys_clk;
  logic        reset;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic [1:0]  gear;
  logic [11:0] pedal_pos;
  logic [7:0]  target_speed;
  logic [7:0]  speed;
  logic        dir_rev;
  logic        speed_tick;
  logic        motor_fwd;
  logic        motor_rev;

  int compareCount = 0;
  int failCount    = 0;

  typedef struct {
    string tag;
    int    spd;
    int    dir;
  } exp_t;

  exp_t expQ[$];
  bit   armed = 1'b0;

  pedal_speed_ramp #(
    .AVG_LOG2 (2),
    .TICK_DIV (4)
  ) dut (
    .sys_clk          (sys_clk),
    .reset            (reset),
    .response_valid   (response_valid),
    .response_channel (response_channel),
    .response_data    (response_data),
    .gear             (gear),
    .pedal_pos        (pedal_pos),
    .target_speed     (target_speed),
    .speed            (speed),
    .dir_rev          (dir_rev),
    .speed_tick       (speed_tick),
    .motor_fwd        (motor_fwd),
    .motor_rev        (motor_rev)
  );

  // Free-running 10 ns system clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compareCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One ADC response strobe; called at posedge+1, returns at posedge+1
  task automatic applyStimulus(input logic [4:0] ch, input logic [11:0] data);
    response_valid   = 1'b1;
    response_channel = ch;
    response_data    = data;
    @(posedge sys_clk);
    #1;
    response_valid   = 1'b0;
  endtask

  task automatic feedBlock(input logic [11:0] data);
    for (int i = 0; i < 4; i++) applyStimulus(5'd1, data);
  endtask

  task automatic settle();
    repeat (2) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Wait for the next tick edge; returns at posedge+1 just after it
  task automatic waitTick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sys_clk);
      if (speed_tick) seen = 1'b1;
    end
    if (!seen) checkOutput("tick_timeout", 0, 1);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pushExpect(input string tag, input int spd, input int dir);
    exp_t e;
    e.tag = tag;
    e.spd = spd;
    e.dir = dir;
    expQ.push_back(e);
  endtask

  task automatic expectTick(input string tag, input int spd, input int dir);
    pushExpect(tag, spd, dir);
    waitTick();
  endtask

  // Reset pulse: everything clears on the next edge, tick counter restarts at 0
  task automatic applyReset(input string tag);
    reset = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput({tag, "_speed"},  int'(speed), 0);
    checkOutput({tag, "_pedal"},  int'(pedal_pos), 0);
    checkOutput({tag, "_target"}, int'(target_speed), 0);
    checkOutput({tag, "_dir"},    int'(dir_rev), 0);
    checkOutput({tag, "_mfwd"},   int'(motor_fwd), 0);
    checkOutput({tag, "_mrev"},   int'(motor_rev), 0);
    checkOutput({tag, "_tick0"},  int'(speed_tick), 0);
    reset = 1'b0;
    settle();
    checkOutput({tag, "_tick2"},  int'(speed_tick), 0);
    @(posedge sys_clk);
    #1;
    checkOutput({tag, "_tick3"},  int'(speed_tick), 1);
  endtask

  // Scoreboard monitor: arm on a tick cycle with work queued, compare after the tick edge
  always @(negedge sys_clk) begin
    exp_t e;
    if (armed) begin
      e = expQ.pop_front();
      checkOutput({e.tag, "_speed"}, int'(speed), e.spd);
      checkOutput({e.tag, "_dir"},   int'(dir_rev), e.dir);
      checkOutput({e.tag, "_mfwd"},  int'(motor_fwd), (e.dir == 0 && e.spd >= 10) ? 1 : 0);
      checkOutput({e.tag, "_mrev"},  int'(motor_rev), (e.dir == 1 && e.spd >= 10) ? 1 : 0);
      checkOutput({e.tag, "_mboth"}, int'(motor_fwd & motor_rev), 0);
      armed = 1'b0;
    end
    if (speed_tick && expQ.size() > 0) armed = 1'b1;
  end

  // Safety net so the run always ends with a summary
  initial begin
    #100000;
    checkOutput("watchdog", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  // Directed scenario sequence
  initial begin
    reset            = 1'b1;
    response_valid   = 1'b0;
    response_channel = 5'd0;
    response_data    = 12'd0;
    gear             = 2'b00;

    applyReset("rst_init");

    // other-channel samples must be neither summed nor counted
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd2, 12'd4095);
      applyStimulus(5'd1, 12'd0);
    end
    settle();
    checkOutput("ch_filter_pedal",  int'(pedal_pos), 0);
    checkOutput("ch_filter_target", int'(target_speed), 0);

    // full pedal, ramp from standstill to the top speed and hold
    feedBlock(12'd4095);
    settle();
    checkOutput("full_pedal",  int'(pedal_pos), 4095);
    checkOutput("full_target", int'(target_speed), 224);
    gear = 2'b10;
    expectTick("ramp_start", 0, 0);
    for (int s = 2; s <= 224; s += 2) expectTick("ramp_up", s, 0);
    expectTick("ramp_hold", 224, 0);
    expectTick("ramp_hold", 224, 0);

    // reset mid-ramp at speed 40
    gear = 2'b00;
    applyReset("rst_top");
    feedBlock(12'd2185);
    settle();
    checkOutput("t120_target", int'(target_speed), 120);
    gear = 2'b10;
    expectTick("r40_start", 0, 0);
    for (int s = 2; s <= 40; s += 2) expectTick("r40_up", s, 0);
    applyReset("rst_mid");

    // ramp to 120, then lower the target to 56 with the last sample on a tick
    feedBlock(12'd2185);
    settle();
    gear = 2'b10;
    expectTick("r120_start", 0, 0);
    for (int s = 2; s <= 120; s += 2) expectTick("r120_up", s, 0);
    expectTick("r120_hold", 120, 0);
    pushExpect("tickcyc_sample", 120, 0);
    feedBlock(12'd1020);
    checkOutput("tickcyc_pedal", int'(pedal_pos), 1020);
    for (int s = 119; s >= 56; s--) expectTick("fall56", s, 0);
    expectTick("hold56", 56, 0);
    expectTick("hold56", 56, 0);

    // lower to 20, then coast in neutral with full pedal
    pushExpect("to20_first", 56, 0);
    feedBlock(12'd365);
    for (int s = 55; s >= 20; s--) expectTick("fall20", s, 0);
    expectTick("hold20", 20, 0);
    pushExpect("coast_first", 20, 0);
    feedBlock(12'd4095);
    gear = 2'b00;
    for (int s = 19; s >= 0; s--) expectTick("coast", s, 0);
    expectTick("coast_stop", 0, 0);

    // forward to 10, flip to reverse: brake through STOP, then ramp backwards
    feedBlock(12'd1821);
    settle();
    checkOutput("t100_target", int'(target_speed), 100);
    gear = 2'b10;
    expectTick("f10_start", 0, 0);
    for (int s = 2; s <= 10; s += 2) expectTick("f10_up", s, 0);
    gear = 2'b01;
    expectTick("flip_brake", 6, 0);
    expectTick("flip_brake", 2, 0);
    expectTick("flip_stop", 0, 0);
    expectTick("rev_start", 0, 1);
    for (int s = 2; s <= 12; s += 2) expectTick("rev_up", s, 1);

    // park brakes to standstill
    gear = 2'b11;
    expectTick("park", 8, 1);
    expectTick("park", 4, 1);
    expectTick("park_stop", 0, 0);
    expectTick("park_hold", 0, 0);

    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
    checkOutput("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
